// File: rtl/timer_irq_master.sv
// Avalon-MM master that starts an interval timer, services its timeout interrupts
// (status read, then clear write) and counts the serviced timeouts.
module timer_irq_master #(
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] CTRL_RUN     = 16'h0007,
  parameter logic [DATA_W-1:0] CTRL_STOP    = 16'h0008
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              irq,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              tick,
  output logic [15:0]       seconds,
  output logic              running,
  output logic              spurious
);

  typedef enum logic [2:0] {
    StIdle,
    StCfgWr,
    StWaitIrq,
    StRdStat,
    StRdWait,
    StClrWr,
    StStopWr
  } state_t;

  state_t            r_state;
  logic [2:0]        r_lat_cnt;
  logic              r_cs;
  logic              r_wn;
  logic [2:0]        r_addr;
  logic [DATA_W-1:0] r_wd;
  logic              r_tick;
  logic [15:0]       r_seconds;
  logic              r_running;
  logic              r_spurious;
  logic              w_timeout;

  // Only the TO bit matters; masking keeps the whole read word referenced.
  assign w_timeout = |(avm_readdata & {{(DATA_W-1){1'b0}}, 1'b1});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_lat_cnt  <= 3'd0;
      r_cs       <= 1'b0;
      r_wn       <= 1'b1;
      r_addr     <= 3'd0;
      r_wd       <= '0;
      r_tick     <= 1'b0;
      r_seconds  <= 16'h0000;
      r_running  <= 1'b0;
      r_spurious <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (enable) begin
            r_state <= StCfgWr;
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
            r_addr  <= 3'd1;
            r_wd    <= CTRL_RUN;
          end
        end
        StCfgWr: begin
          if (!avm_waitrequest) begin
            r_state   <= StWaitIrq;
            r_cs      <= 1'b0;
            r_wn      <= 1'b1;
            r_addr    <= 3'd0;
            r_wd      <= '0;
            r_running <= 1'b1;
          end
        end
        StWaitIrq: begin
          if (irq) begin
            r_state <= StRdStat;
            r_cs    <= 1'b1;
            r_wn    <= 1'b1;
            r_addr  <= 3'd0;
          end else if (!enable) begin
            r_state <= StStopWr;
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
            r_addr  <= 3'd1;
            r_wd    <= CTRL_STOP;
          end
        end
        StRdStat: begin
          if (!avm_waitrequest) begin
            r_state   <= StRdWait;
            r_cs      <= 1'b0;
            r_lat_cnt <= 3'd1;
          end
        end
        StRdWait: begin
          // Counter equals READ_LATENCY on the edge exactly that many cycles after accept.
          if (r_lat_cnt == 3'(READ_LATENCY)) begin
            if (w_timeout) begin
              r_state <= StClrWr;
              r_cs    <= 1'b1;
              r_wn    <= 1'b0;
              r_addr  <= 3'd0;
              r_wd    <= '0;
            end else begin
              r_spurious <= 1'b1;
              if (enable) begin
                r_state <= StWaitIrq;
              end else begin
                r_state <= StStopWr;
                r_cs    <= 1'b1;
                r_wn    <= 1'b0;
                r_addr  <= 3'd1;
                r_wd    <= CTRL_STOP;
              end
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        StClrWr: begin
          if (!avm_waitrequest) begin
            r_tick    <= 1'b1;
            r_seconds <= r_seconds + 16'h0001;
            if (enable) begin
              r_state <= StWaitIrq;
              r_cs    <= 1'b0;
              r_wn    <= 1'b1;
              r_addr  <= 3'd0;
              r_wd    <= '0;
            end else begin
              r_state <= StStopWr;
              r_cs    <= 1'b1;
              r_wn    <= 1'b0;
              r_addr  <= 3'd1;
              r_wd    <= CTRL_STOP;
            end
          end
        end
        StStopWr: begin
          if (!avm_waitrequest) begin
            r_state   <= StIdle;
            r_cs      <= 1'b0;
            r_wn      <= 1'b1;
            r_addr    <= 3'd0;
            r_wd      <= '0;
            r_running <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_wn;
  assign avm_address    = r_addr;
  assign avm_writedata  = r_wd;
  assign tick           = r_tick;
  assign seconds        = r_seconds;
  assign running        = r_running;
  assign spurious       = r_spurious;

endmodule

// File: tb/tb_timer_irq_master.sv
// Scoreboard bench: two masters (read latency 1 and 3) against a small timer-slave model.
module tb_timer_irq_master;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  en, irq, wreq, cs, wn, tick, run, spur;
  logic [2:0]  addr  [2];
  logic [15:0] wd    [2];
  logic [15:0] rdata [2];
  logic [15:0] sec   [2];
  logic [15:0] stat;
  int unsigned rcnt  [2];

  int          n_total = 0;
  int          n_bad   = 0;
  logic [19:0] exp_q [$];
  logic [1:0]  tick_due;
  logic [15:0] exp_sec [2];
  int          sel;

  timer_irq_master #(.DATA_W(16), .READ_LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .enable(en[0]), .irq(irq[0]),
    .avm_address(addr[0]), .avm_chipselect(cs[0]), .avm_write_n(wn[0]),
    .avm_writedata(wd[0]), .avm_readdata(rdata[0]), .avm_waitrequest(wreq[0]),
    .tick(tick[0]), .seconds(sec[0]), .running(run[0]), .spurious(spur[0])
  );

  timer_irq_master #(.DATA_W(16), .READ_LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .enable(en[1]), .irq(irq[1]),
    .avm_address(addr[1]), .avm_chipselect(cs[1]), .avm_write_n(wn[1]),
    .avm_writedata(wd[1]), .avm_readdata(rdata[1]), .avm_waitrequest(wreq[1]),
    .tick(tick[1]), .seconds(sec[1]), .running(run[1]), .spurious(spur[1])
  );

  // Read data is valid only in the cycle the master must sample; bit 0 is inverted otherwise.
  assign rdata[0] = (rcnt[0] == 1) ? stat : (stat ^ 16'h0001);
  assign rdata[1] = (rcnt[1] == 1) ? stat : (stat ^ 16'h0001);

  function automatic int unsigned lat(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic push(input logic w, input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back({w, a, d});
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt[0] <= 0;
      rcnt[1] <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (cs[k] && !wreq[k] && wn[k]) rcnt[k] <= lat(k);
        else if (rcnt[k] != 0)          rcnt[k] <= rcnt[k] - 1;
      end
    end
  end

  // Bus monitor: everything is stable at the falling edge; acceptance happens on the next rise.
  always @(negedge clk) begin
    logic [19:0] got;
    logic [19:0] e;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        check("tick", 32'(tick[k]), 32'(tick_due[k]));
        if (tick_due[k]) begin
          exp_sec[k] = exp_sec[k] + 16'h0001;
          check("seconds", 32'(sec[k]), 32'(exp_sec[k]));
        end
        tick_due[k] = 1'b0;
        if (cs[k]) begin
          if (!wreq[k]) begin
            got = {~wn[k], addr[k], wn[k] ? 16'h0000 : wd[k]};
            if (exp_q.size() == 0) begin
              check("txn_extra", {11'd0, 1'b1, got}, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("txn", 32'(got), 32'(e));
            end
            if (!wn[k] && addr[k] == 3'd0) tick_due[k] = 1'b1;
          end
        end else begin
          check("bus_idle", 32'({wn[k], addr[k], wd[k]}), 32'({1'b1, 3'd0, 16'h0000}));
        end
      end
    end
  end

  task automatic wait_q(input int n, input string tag);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() <= n) break;
    end
    check(tag, 32'(exp_q.size() <= n), 32'd1);
  endtask

  task automatic wait_cs(input logic want_wn, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = cs[sel] && (wn[sel] == want_wn);
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic service(input logic [15:0] s, input int stall);
    stat = s;
    irq[sel] = 1'b1;
    push(1'b0, 3'd0, 16'h0000);
    if (s[0]) push(1'b1, 3'd0, 16'h0000);
    wait_q(s[0] ? 1 : 0, "rd_accept");
    irq[sel] = 1'b0;
    if (stall > 0) begin
      wreq[sel] = 1'b1;
      wait_cs(1'b0, "clr_shown");
      repeat (stall) begin
        @(negedge clk);
        check("clr_hold", 32'({cs[sel], wn[sel], addr[sel], wd[sel]}),
              32'({1'b1, 1'b0, 3'd0, 16'h0000}));
      end
      @(posedge clk);
      #1;
      wreq[sel] = 1'b0;
    end
    wait_q(0, "svc_done");
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en = '0; irq = '0; wreq = '0; stat = 16'h0000;
    tick_due = '0; exp_sec[0] = 16'h0000; exp_sec[1] = 16'h0000;
    sel = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_bus", 32'({cs[k], wn[k], addr[k], wd[k]}), 32'({1'b0, 1'b1, 3'd0, 16'h0000}));
      check("rst_flags", 32'({tick[k], run[k], spur[k], sec[k]}), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Master A, read latency 1
    sel = 0;
    en[0] = 1'b1;
    push(1'b1, 3'd1, 16'h0007);
    wait_q(0, "cfg_a");
    @(negedge clk);
    check("run_a", 32'(run[0]), 32'd1);
    service(16'h0003, 0);
    check("sec_a1", 32'(sec[0]), 32'd1);
    service(16'h0003, 5);
    check("sec_a2", 32'(sec[0]), 32'd2);
    service(16'h0002, 0);
    check("spur_a", 32'(spur[0]), 32'd1);
    check("sec_a_spur", 32'(sec[0]), 32'd2);

    force dut_a.r_seconds = 16'hFFFF;
    exp_sec[0] = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut_a.r_seconds;
    service(16'h0003, 0);
    check("sec_wrap", 32'(sec[0]), 32'd0);

    // Re-enable during a stalled stop write must wait for idle, then restart.
    wreq[0] = 1'b1;
    en[0] = 1'b0;
    push(1'b1, 3'd1, 16'h0008);
    wait_cs(1'b0, "stop_shown");
    @(posedge clk);
    #1;
    en[0] = 1'b1;
    push(1'b1, 3'd1, 16'h0007);
    repeat (3) begin
      @(negedge clk);
      check("stop_hold", 32'({cs[0], wn[0], addr[0], wd[0]}), 32'({1'b1, 1'b0, 3'd1, 16'h0008}));
    end
    @(posedge clk);
    #1;
    wreq[0] = 1'b0;
    wait_q(0, "restart");
    @(negedge clk);
    check("run_restart", 32'(run[0]), 32'd1);

    // Master B, read latency 3
    sel = 1;
    en[1] = 1'b1;
    push(1'b1, 3'd1, 16'h0007);
    wait_q(0, "cfg_b");
    service(16'h0003, 0);
    check("sec_b1", 32'(sec[1]), 32'd1);

    // irq still high after the clear: re-read sees status 0 and flags spurious.
    stat = 16'h0003;
    irq[1] = 1'b1;
    push(1'b0, 3'd0, 16'h0000);
    push(1'b1, 3'd0, 16'h0000);
    push(1'b0, 3'd0, 16'h0000);
    wait_q(1, "clr_acc_b");
    stat = 16'h0000;
    wait_q(0, "rd2_acc_b");
    irq[1] = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("spur_b", 32'(spur[1]), 32'd1);
    check("sec_b2", 32'(sec[1]), 32'd2);

    // enable dropped while waiting for read data: finish service, then stop.
    stat = 16'h0003;
    irq[1] = 1'b1;
    push(1'b0, 3'd0, 16'h0000);
    push(1'b1, 3'd0, 16'h0000);
    wait_q(1, "rd_acc_drop");
    en[1] = 1'b0;
    irq[1] = 1'b0;
    push(1'b1, 3'd1, 16'h0008);
    wait_q(0, "stop_b");
    @(negedge clk);
    @(negedge clk);
    check("run_b_off", 32'(run[1]), 32'd0);
    check("sec_b3", 32'(sec[1]), 32'd3);

    // Reset in the middle of a stalled read on master A.
    sel = 0;
    wreq[0] = 1'b1;
    irq[0] = 1'b1;
    wait_cs(1'b1, "rd_shown");
    reset = 1'b1;
    #2;
    check("rst_mid_bus", 32'({cs[0], wn[0], addr[0], wd[0]}), 32'({1'b0, 1'b1, 3'd0, 16'h0000}));
    check("rst_mid_flags", 32'({run[0], spur[0], sec[0]}), 32'd0);
    exp_q.delete();
    tick_due = '0;
    exp_sec[0] = 16'h0000;
    exp_sec[1] = 16'h0000;
    en = '0; irq = '0; wreq = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("post_rst_run", 32'(run[0]), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_irq_master.md
TIMER_IRQ_MASTER -- requirements
Module: timer_irq_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bus data width.
REQ-002 SHALL have parameter READ_LATENCY, default 1, meaning cycles from accepted read to valid avm_readdata (range 1-4).
REQ-003 SHALL have parameter CTRL_RUN, default 16'h0007, meaning control word written to start the timer (ITO|CONT|START).
REQ-004 SHALL have parameter CTRL_STOP, default 16'h0008, meaning control word written to stop the timer (STOP).
REQ-005 SHALL have ports: clk  in  1  single clock; reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: enable  in  1  level request to run the timer; irq  in  1  timer interrupt, level.
REQ-007 SHALL have ports: avm_address  out  3  word address; avm_chipselect  out  1; avm_write_n  out  1  low = write.
REQ-008 SHALL have ports: avm_writedata  out  DATA_W; avm_readdata  in  DATA_W; avm_waitrequest  in  1  slave stall.
REQ-009 SHALL have ports: tick  out  1  one-cycle pulse per serviced timeout; seconds  out  16  tick count; running  out  1; spurious  out  1  sticky flag.

Function
REQ-010 SHALL implement states IDLE, CFG_WR, WAIT_IRQ, RD_STAT, RD_WAIT, CLR_WR, STOP_WR.
REQ-011 Bus write: chipselect=1, write_n=0, address/writedata stable; held until a cycle with avm_waitrequest=0, which accepts it.
REQ-012 Bus read: chipselect=1, write_n=1, address stable; held until avm_waitrequest=0; avm_readdata sampled exactly READ_LATENCY cycles after the accepting edge.
REQ-013 Outside an active transaction: chipselect=0, write_n=1, address=0, writedata=0.
REQ-014 IDLE -> CFG_WR when enable=1; CFG_WR writes CTRL_RUN to address 1; on accept -> WAIT_IRQ, running=1.
REQ-015 WAIT_IRQ: irq=1 -> RD_STAT (irq takes priority); else enable=0 -> STOP_WR.
REQ-016 RD_STAT reads address 0; on accept -> RD_WAIT, counting READ_LATENCY cycles.
REQ-017 RD_WAIT at sample: readdata[0]=1 -> CLR_WR; readdata[0]=0 -> set spurious, then back to WAIT_IRQ if enable=1, else STOP_WR.
REQ-018 CLR_WR writes 16'h0000 to address 0; on accept: tick=1 for that cycle, seconds+1 (wraps 16'hFFFF -> 0); then WAIT_IRQ if enable=1, else STOP_WR.
REQ-019 STOP_WR writes CTRL_STOP to address 1; on accept -> IDLE, running=0.
REQ-020 enable deasserted mid-transaction or mid-service SHALL NOT abort; sequence completes, stop follows.
REQ-021 enable re-asserted while in STOP_WR SHALL be ignored until IDLE is reached; IDLE then restarts on the next cycle.
REQ-022 Exactly one bus transaction outstanding at any time; no new request before read data sampled.
REQ-023 irq still high on return to WAIT_IRQ (clear not yet propagated) SHALL trigger a new RD_STAT; a status of 0 then sets spurious, not tick.

Reset
REQ-024 reset=1 asynchronously forces IDLE; tick=0, seconds=0, running=0, spurious=0, chipselect=0, write_n=1, address=0, writedata=0.
REQ-025 Reset mid-transaction drops the request immediately; no partial state survives; spurious cleared only by reset.

Verification
REQ-026 enable=1, waitrequest=0 -> next cycles: write addr1 data 0x0007, running=1, bus idle.
REQ-027 irq=1, status read returns 0x0003 -> write addr0 0x0000, tick one cycle, seconds 0->1.
REQ-028 waitrequest=1 for 5 cycles during CLR_WR -> address/data held 5 cycles, tick only on accept.
REQ-029 seconds=0xFFFF plus one serviced timeout -> seconds=0x0000, tick=1.
REQ-030 irq=1, status returns 0x0002 -> spurious=1, no tick, no write to addr0.
REQ-031 enable dropped during RD_WAIT -> clear write, then write addr1 0x0008, IDLE, running=0; READ_LATENCY=3 repeat, sampling exactly 3 cycles after accept.
